// File: rtl/i2c_int_coalescer_pkg.sv
// Shared constants and types for the I2C interrupt coalescer: register offsets,
// event bit positions, coalescing FSM states and counter widths.
package i2c_int_pkg;

  localparam int CNT_W = 8;
  localparam int TMO_W = 16;

  localparam logic [7:0] OFF_PEND = 8'h00;
  localparam logic [7:0] OFF_EN   = 8'h04;
  localparam logic [7:0] OFF_CNT  = 8'h08;
  localparam logic [7:0] OFF_THR  = 8'h40;
  localparam logic [7:0] OFF_TMO  = 8'h44;
  localparam logic [7:0] OFF_IRQ  = 8'h48;

  localparam int EVT_BUS_BUSY   = 0;
  localparam int EVT_ADDR_MATCH = 1;
  localparam int EVT_RX_DONE    = 2;
  localparam int EVT_TX_DONE    = 3;
  localparam int EVT_RX_ACK     = 4;
  localparam int EVT_ARB_LOST   = 5;
  localparam int EVT_START_DET  = 6;
  localparam int EVT_STOP_DET   = 7;

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE} coal_state_t;

  // Byte offset of a per-channel register inside the 0x10-stride channel blocks.
  function automatic logic [7:0] chan_off(input int c, input logic [7:0] off);
    return 8'(c * 16) + off;
  endfunction

endpackage

// File: rtl/i2c_int_coalescer_if.sv
// APB slave window of the interrupt coalescer.
interface i2c_int_coalescer_if #(
  parameter int APB_AW = 12,
  parameter int APB_DW = 32
) ();
  logic [APB_AW-1:0] paddr;
  logic              pwrite;
  logic [APB_DW-1:0] pwdata;
  logic              psel;
  logic              penable;
  logic [APB_DW-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (output paddr, pwrite, pwdata, psel, penable,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, pwrite, pwdata, psel, penable,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/i2c_int_coalescer_chan.sv
// One channel: edge detect, sticky PEND, EN mask, saturating event count,
// timeout timer and the IDLE/ACCUM/FIRE coalescing FSM.
module i2c_int_chan
  import i2c_int_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic [31:0]      int_raw,
  input  logic [CNT_W-1:0] thr,
  input  logic [TMO_W-1:0] tmo,
  input  logic [7:1]       pend_w1c,
  input  logic             en_we,
  input  logic [7:1]       en_wdata,
  output logic [7:0]       pend_rd,
  output logic [7:0]       en_rd,
  output logic [CNT_W-1:0] cnt,
  output logic             firing
);

  logic [7:1]       raw_q, raw_d, pend_q, pend_d, en_q, en_d, evt;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W:0]   cnt_sum;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  coal_state_t      state_q, state_d;
  logic             en_evt, en_pend, thr_hit, tmo_hit;
  logic             unused_raw;

  assign unused_raw = ^int_raw[31:8];

  always_comb begin
    raw_d   = int_raw[7:1];
    evt     = int_raw[7:1] & ~raw_q;
    // A rising event beats a same-cycle W1C of that bit.
    pend_d  = (pend_q & ~pend_w1c) | evt;
    en_d    = en_we ? en_wdata : en_q;
    en_evt  = |(evt & en_q);
    en_pend = |(pend_d & en_d);
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(en_evt);
    cnt_inc = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    thr_hit = cnt_sum >= {1'b0, thr};
    tmo_hit = (tmo != '0) && ((tmr_q + TMO_W'(1)) == tmo);

    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (en_evt && en_pend) begin
          cnt_d   = cnt_inc;
          tmr_d   = '0;
          state_d = thr_hit ? FIRE : ACCUM;
        end
      end
      ACCUM: begin
        if (!en_pend) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmr_d   = '0;
        end else if (thr_hit || tmo_hit) begin
          state_d = FIRE;
          cnt_d   = cnt_inc;
          tmr_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          tmr_d = tmr_q + TMO_W'(1);
        end
      end
      FIRE: begin
        if (!en_pend) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      raw_q   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      state_q <= IDLE;
    end else begin
      raw_q   <= raw_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      state_q <= state_d;
    end
  end

  assign pend_rd = {pend_q, int_raw[EVT_BUS_BUSY]};
  assign en_rd   = {en_q, 1'b0};
  assign cnt     = cnt_q;
  assign firing  = (state_q == FIRE);

endmodule

// File: rtl/i2c_int_coalescer.sv
// Interrupt coalescer top: APB register window, global THR/TMO registers,
// NUM_CH channel instances and the registered per-channel and combined IRQs.
module i2c_int_coalescer
  import i2c_int_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int APB_DW = 32,
  parameter int APB_AW = 12
) (
  input  logic                   clk_apb,
  input  logic                   rst_apb,
  i2c_int_coalescer_if.slave     apb,
  input  logic [NUM_CH*32-1:0]   int_raw,
  output logic [NUM_CH-1:0]      irq_ch,
  output logic                   irq
);

  logic [NUM_CH-1:0][7:0]       pend_rd, en_rd;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_rd;
  logic [NUM_CH-1:0][7:1]       w1c;
  logic [NUM_CH-1:0]            en_we, firing;
  logic [CNT_W-1:0]             thr_q, thr_d, thr_eff;
  logic [TMO_W-1:0]             tmo_q, tmo_d;
  logic [APB_DW-1:0]            prdata_q, prdata_d, rdata;
  logic                         pready_q, pready_d, pslverr_q, pslverr_d;
  logic [NUM_CH-1:0]            irq_ch_q, irq_ch_d;
  logic                         irq_q, irq_d;
  logic [7:0]                   addr_lo;
  logic                         access, hit, ro, err, wr_ok;
  logic                         unused_wdata;

  assign unused_wdata = ^apb.pwdata[APB_DW-1:TMO_W];
  assign addr_lo      = apb.paddr[7:0];
  // pready_q doubles as the done flag so a held access phase commits once.
  assign access       = apb.psel && apb.penable && !pready_q;

  always_comb begin
    hit = 1'b0;
    ro  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr_lo == chan_off(c, OFF_PEND) || addr_lo == chan_off(c, OFF_EN)) hit = 1'b1;
      if (addr_lo == chan_off(c, OFF_CNT)) begin
        hit = 1'b1;
        ro  = 1'b1;
      end
    end
    if (addr_lo == OFF_THR || addr_lo == OFF_TMO) hit = 1'b1;
    if (addr_lo == OFF_IRQ) begin
      hit = 1'b1;
      ro  = 1'b1;
    end
    if (apb.paddr[APB_AW-1:8] != '0) hit = 1'b0;
    err   = !hit || (apb.pwrite && ro);
    wr_ok = access && apb.pwrite && !err;
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr_lo == chan_off(c, OFF_PEND)) rdata = APB_DW'(pend_rd[c]);
      if (addr_lo == chan_off(c, OFF_EN))   rdata = APB_DW'(en_rd[c]);
      if (addr_lo == chan_off(c, OFF_CNT))  rdata = APB_DW'(cnt_rd[c]);
    end
    if (addr_lo == OFF_THR) rdata = APB_DW'(thr_q);
    if (addr_lo == OFF_TMO) rdata = APB_DW'(tmo_q);
    if (addr_lo == OFF_IRQ) rdata = APB_DW'(irq_ch_q);

    thr_d     = (wr_ok && addr_lo == OFF_THR) ? apb.pwdata[CNT_W-1:0] : thr_q;
    tmo_d     = (wr_ok && addr_lo == OFF_TMO) ? apb.pwdata[TMO_W-1:0] : tmo_q;
    pready_d  = access;
    pslverr_d = access && err;
    prdata_d  = (access && !err && !apb.pwrite) ? rdata : '0;
    irq_ch_d  = firing;
    irq_d     = |firing;
  end

  assign thr_eff = (thr_q == '0) ? CNT_W'(1) : thr_q;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign w1c[gi]   = (wr_ok && addr_lo == chan_off(gi, OFF_PEND)) ? apb.pwdata[7:1] : '0;
      assign en_we[gi] = wr_ok && addr_lo == chan_off(gi, OFF_EN);

      i2c_int_chan u_chan (
        .clk      (clk_apb),
        .srst     (rst_apb),
        .int_raw  (int_raw[32*gi +: 32]),
        .thr      (thr_eff),
        .tmo      (tmo_q),
        .pend_w1c (w1c[gi]),
        .en_we    (en_we[gi]),
        .en_wdata (apb.pwdata[7:1]),
        .pend_rd  (pend_rd[gi]),
        .en_rd    (en_rd[gi]),
        .cnt      (cnt_rd[gi]),
        .firing   (firing[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_apb) begin
    if (rst_apb) begin
      thr_q     <= CNT_W'(1);
      tmo_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      irq_ch_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      thr_q     <= thr_d;
      tmo_q     <= tmo_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      irq_ch_q  <= irq_ch_d;
      irq_q     <= irq_d;
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign irq_ch      = irq_ch_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_i2c_int_coalescer.sv
// Scenario bench for i2c_int_coalescer: APB responses go through an expected/observed
// queue pair, interrupt timing is checked inline on falling clock edges.
module tb_i2c_int_coalescer;

  localparam int NUM_CH = 4;

  logic                 clk_apb = 1'b0;
  logic                 rst_apb = 1'b1;
  logic [NUM_CH*32-1:0] int_raw = '0;
  logic [NUM_CH-1:0]    irq_ch;
  logic                 irq;

  i2c_int_coalescer_if #(.APB_AW(12), .APB_DW(32)) apb_if ();

  i2c_int_coalescer #(.NUM_CH(NUM_CH), .APB_DW(32), .APB_AW(12)) dut (
    .clk_apb (clk_apb),
    .rst_apb (rst_apb),
    .apb     (apb_if),
    .int_raw (int_raw),
    .irq_ch  (irq_ch),
    .irq     (irq)
  );

  always #5 clk_apb = ~clk_apb;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic apb_xfer(input string name, input logic [11:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input logic exp_err);
    txn_t e, o;
    int   n;
    e.name = name; e.data = exp_data; e.err = exp_err; e.chk_data = !wr || exp_err;
    exp_q.push_back(e);
    @(negedge clk_apb);
    apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.paddr = addr;
    apb_if.pwrite = wr; apb_if.pwdata = wdata;
    @(negedge clk_apb);
    apb_if.penable = 1'b1;
    n = 0;
    do begin
      @(negedge clk_apb);
      n++;
    end while (apb_if.pready !== 1'b1 && n < 8);
    o.name = name;
    o.data = apb_if.prdata;
    o.err  = (apb_if.pready === 1'b1) ? apb_if.pslverr : 1'bx;
    o.chk_data = 1'b0;
    obs_q.push_back(o);
    $display("apb %s %s addr=0x%03h wdata=0x%08h rdata=0x%08h err=%b",
             name, wr ? "wr" : "rd", addr, wdata, o.data, o.err);
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
  endtask

  task automatic pulse(input int ch, input int bit_i);
    @(negedge clk_apb);
    int_raw[ch*32 + bit_i] = 1'b1;
    @(negedge clk_apb);
    int_raw[ch*32 + bit_i] = 1'b0;
  endtask

  task automatic test_reset();
    txn_t e, o;
    rst_apb = 1'b1;
    repeat (3) @(negedge clk_apb);
    n_cmp++;
    if ({irq, irq_ch, apb_if.pready, apb_if.pslverr} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got irq=%b irq_ch=%b pready=%b pslverr=%b, want all 0",
               irq, irq_ch, apb_if.pready, apb_if.pslverr);
    end
    n_cmp++;
    if (apb_if.prdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_prdata: got 0x%08h, want 0", apb_if.prdata);
    end
    rst_apb = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      apb_xfer($sformatf("pend%0d", c), 12'(16*c),     1'b0, 32'h0, 32'h0, 1'b0);
      apb_xfer($sformatf("en%0d", c),   12'(16*c + 4), 1'b0, 32'h0, 32'h0, 1'b0);
      apb_xfer($sformatf("cnt%0d", c),  12'(16*c + 8), 1'b0, 32'h0, 32'h0, 1'b0);
    end
    apb_xfer("thr",      12'h040, 1'b0, 32'h0, 32'h1, 1'b0);
    apb_xfer("tmo",      12'h044, 1'b0, 32'h0, 32'h0, 1'b0);
    apb_xfer("irq_stat", 12'h048, 1'b0, 32'h0, 32'h0, 1'b0);
    apb_xfer("bad_4c",   12'h04C, 1'b0, 32'h0, 32'h0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.err !== e.err || (e.chk_data && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL %s: got data=0x%08h err=%b, want data=0x%08h err=%b", e.name, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_single_event();
    txn_t e, o;
    apb_xfer("en1_wr", 12'h014, 1'b1, 32'h08, 32'h0, 1'b0);
    pulse(1, 3);
    n_cmp++;
    if (irq_ch !== 4'b0000) begin
      n_bad++; $display("FAIL single_lat1: got irq_ch=%b, want 0000", irq_ch);
    end
    @(negedge clk_apb);
    n_cmp++;
    if (irq_ch !== 4'b0010 || irq !== 1'b1) begin
      n_bad++; $display("FAIL single_lat2: got irq_ch=%b irq=%b, want 0010/1", irq_ch, irq);
    end
    apb_xfer("pend1_rd",  12'h010, 1'b0, 32'h0,  32'h08, 1'b0);
    apb_xfer("pend1_w1c", 12'h010, 1'b1, 32'h08, 32'h0,  1'b0);
    n_cmp++;
    if (irq_ch !== 4'b0010) begin
      n_bad++; $display("FAIL clear_hold: got irq_ch=%b, want 0010", irq_ch);
    end
    @(negedge clk_apb);
    n_cmp++;
    if (irq_ch !== 4'b0000 || irq !== 1'b0) begin
      n_bad++; $display("FAIL clear_fall: got irq_ch=%b irq=%b, want 0000/0", irq_ch, irq);
    end
    apb_xfer("cnt1_rd",  12'h018, 1'b0, 32'h0, 32'h0, 1'b0);
    apb_xfer("irq_stat", 12'h048, 1'b0, 32'h0, 32'h0, 1'b0);
    apb_xfer("en1_off",  12'h014, 1'b1, 32'h0, 32'h0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.err !== e.err || (e.chk_data && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL %s: got data=0x%08h err=%b, want data=0x%08h err=%b", e.name, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_threshold();
    txn_t e, o;
    apb_xfer("thr3",   12'h040, 1'b1, 32'h3,  32'h0, 1'b0);
    apb_xfer("en0_wr", 12'h004, 1'b1, 32'h04, 32'h0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      pulse(0, 2);
      repeat (3) @(negedge clk_apb);
      n_cmp++;
      if (irq !== 1'b0) begin
        n_bad++; $display("FAIL thr_early_%0d: got irq=%b, want 0", p, irq);
      end
    end
    pulse(0, 2);
    n_cmp++;
    if (irq_ch !== 4'b0000) begin
      n_bad++; $display("FAIL thr_lat1: got irq_ch=%b, want 0000", irq_ch);
    end
    @(negedge clk_apb);
    n_cmp++;
    if (irq_ch !== 4'b0001) begin
      n_bad++; $display("FAIL thr_fire: got irq_ch=%b, want 0001", irq_ch);
    end
    apb_xfer("cnt0_rd",  12'h008, 1'b0, 32'h0,  32'h3, 1'b0);
    apb_xfer("pend0_w1c",12'h000, 1'b1, 32'h04, 32'h0, 1'b0);
    apb_xfer("en0_off",  12'h004, 1'b1, 32'h0,  32'h0, 1'b0);
    apb_xfer("thr1",     12'h040, 1'b1, 32'h1,  32'h0, 1'b0);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL thr_cleanup: got irq=%b, want 0", irq);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.err !== e.err || (e.chk_data && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL %s: got data=0x%08h err=%b, want data=0x%08h err=%b", e.name, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_timeout();
    txn_t e, o;
    int   m;
    apb_xfer("thr10",  12'h040, 1'b1, 32'd10, 32'h0, 1'b0);
    apb_xfer("tmo20",  12'h044, 1'b1, 32'd20, 32'h0, 1'b0);
    apb_xfer("en2_wr", 12'h024, 1'b1, 32'h02, 32'h0, 1'b0);
    pulse(2, 1);
    m = 1;
    while (irq_ch[2] !== 1'b1 && m < 60) begin
      @(negedge clk_apb);
      m++;
    end
    n_cmp++;
    if (m != 22) begin
      n_bad++; $display("FAIL tmo_latency: got %0d cycles, want 22", m);
    end
    apb_xfer("cnt2_rd",   12'h028, 1'b0, 32'h0,  32'h1, 1'b0);
    apb_xfer("pend2_w1c", 12'h020, 1'b1, 32'h02, 32'h0, 1'b0);
    apb_xfer("en2_off",   12'h024, 1'b1, 32'h0,  32'h0, 1'b0);
    apb_xfer("thr1",      12'h040, 1'b1, 32'h1,  32'h0, 1'b0);
    apb_xfer("tmo0",      12'h044, 1'b1, 32'h0,  32'h0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.err !== e.err || (e.chk_data && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL %s: got data=0x%08h err=%b, want data=0x%08h err=%b", e.name, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_disabled_event();
    txn_t e, o;
    pulse(0, 5);
    repeat (3) @(negedge clk_apb);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL dis_irq: got irq=%b, want 0", irq);
    end
    apb_xfer("pend0_rd", 12'h000, 1'b0, 32'h0,  32'h20, 1'b0);
    apb_xfer("cnt0_rd",  12'h008, 1'b0, 32'h0,  32'h0,  1'b0);
    apb_xfer("en0_late", 12'h004, 1'b1, 32'h20, 32'h0,  1'b0);
    repeat (4) @(negedge clk_apb);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL dis_late_en: got irq=%b, want 0", irq);
    end
    apb_xfer("cnt0_rd2", 12'h008, 1'b0, 32'h0, 32'h0, 1'b0);
    int_raw[0] = 1'b1;
    apb_xfer("pend0_live", 12'h000, 1'b0, 32'h0, 32'h21, 1'b0);
    int_raw[0] = 1'b0;
    apb_xfer("pend0_w1c", 12'h000, 1'b1, 32'h20, 32'h0, 1'b0);
    apb_xfer("en0_off",   12'h004, 1'b1, 32'h0,  32'h0, 1'b0);
    apb_xfer("pend0_rd2", 12'h000, 1'b0, 32'h0,  32'h0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.err !== e.err || (e.chk_data && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL %s: got data=0x%08h err=%b, want data=0x%08h err=%b", e.name, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_errors();
    txn_t e, o;
    apb_xfer("wr_cnt0",  12'h008, 1'b1, 32'h5, 32'h0, 1'b1);
    apb_xfer("wr_irq",   12'h048, 1'b1, 32'h5, 32'h0, 1'b1);
    apb_xfer("wr_thr_m", 12'h041, 1'b1, 32'h7, 32'h0, 1'b1);
    apb_xfer("rd_0x001", 12'h001, 1'b0, 32'h0, 32'h0, 1'b1);
    apb_xfer("rd_0x140", 12'h140, 1'b0, 32'h0, 32'h0, 1'b1);
    apb_xfer("wr_0x144", 12'h144, 1'b1, 32'h9, 32'h0, 1'b1);
    apb_xfer("thr_kept", 12'h040, 1'b0, 32'h0, 32'h1, 1'b0);
    apb_xfer("tmo_kept", 12'h044, 1'b0, 32'h0, 32'h0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.err !== e.err || (e.chk_data && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL %s: got data=0x%08h err=%b, want data=0x%08h err=%b", e.name, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    txn_t e, o;
    apb_xfer("en3_wr", 12'h034, 1'b1, 32'h80, 32'h0, 1'b0);
    pulse(3, 7);
    @(negedge clk_apb);
    n_cmp++;
    if (irq_ch !== 4'b1000) begin
      n_bad++; $display("FAIL race_pre: got irq_ch=%b, want 1000", irq_ch);
    end
    fork
      apb_xfer("pend3_w1c_race", 12'h030, 1'b1, 32'h80, 32'h0, 1'b0);
      begin
        @(negedge clk_apb);
        @(negedge clk_apb);
        int_raw[3*32 + 7] = 1'b1;
        @(negedge clk_apb);
        int_raw[3*32 + 7] = 1'b0;
      end
    join
    repeat (2) @(negedge clk_apb);
    n_cmp++;
    if (irq_ch !== 4'b1000) begin
      n_bad++; $display("FAIL race_hold: got irq_ch=%b, want 1000", irq_ch);
    end
    apb_xfer("pend3_rd", 12'h030, 1'b0, 32'h0, 32'h80, 1'b0);
    apb_xfer("cnt3_two", 12'h038, 1'b0, 32'h0, 32'd2,  1'b0);
    for (int i = 0; i < 100; i++) pulse(3, 7);
    apb_xfer("cnt3_102", 12'h038, 1'b0, 32'h0, 32'd102, 1'b0);
    for (int i = 0; i < 200; i++) pulse(3, 7);
    apb_xfer("cnt3_sat", 12'h038, 1'b0, 32'h0, 32'd255, 1'b0);
    apb_xfer("pend3_w1c", 12'h030, 1'b1, 32'h80, 32'h0, 1'b0);
    @(negedge clk_apb);
    n_cmp++;
    if (irq_ch !== 4'b0000 || irq !== 1'b0) begin
      n_bad++; $display("FAIL sat_clear: got irq_ch=%b irq=%b, want 0000/0", irq_ch, irq);
    end
    apb_xfer("cnt3_clr", 12'h038, 1'b0, 32'h0, 32'h0, 1'b0);
    apb_xfer("en3_off",  12'h034, 1'b1, 32'h0, 32'h0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.err !== e.err || (e.chk_data && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL %s: got data=0x%08h err=%b, want data=0x%08h err=%b", e.name, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    txn_t e, o;
    apb_xfer("en1_wr", 12'h014, 1'b1, 32'h02, 32'h0, 1'b0);
    pulse(1, 1);
    @(negedge clk_apb);
    n_cmp++;
    if (irq_ch !== 4'b0010) begin
      n_bad++; $display("FAIL mid_pre: got irq_ch=%b, want 0010", irq_ch);
    end
    @(negedge clk_apb);
    apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.paddr = 12'h040;
    apb_if.pwrite = 1'b1; apb_if.pwdata = 32'h5;
    @(negedge clk_apb);
    apb_if.penable = 1'b1;
    rst_apb = 1'b1;
    @(negedge clk_apb);
    n_cmp++;
    if ({irq, irq_ch, apb_if.pready, apb_if.pslverr} !== 7'b0) begin
      n_bad++;
      $display("FAIL mid_reset_out: got irq=%b irq_ch=%b pready=%b pslverr=%b, want all 0",
               irq, irq_ch, apb_if.pready, apb_if.pslverr);
    end
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    rst_apb = 1'b0;
    apb_xfer("thr_rst",  12'h040, 1'b0, 32'h0, 32'h1, 1'b0);
    apb_xfer("en1_rst",  12'h014, 1'b0, 32'h0, 32'h0, 1'b0);
    apb_xfer("pend1_rst",12'h010, 1'b0, 32'h0, 32'h0, 1'b0);
    apb_xfer("cnt1_rst", 12'h018, 1'b0, 32'h0, 32'h0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.err !== e.err || (e.chk_data && o.data !== e.data)) begin
        n_bad++;
        $display("FAIL %s: got data=0x%08h err=%b, want data=0x%08h err=%b", e.name, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  initial begin
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    apb_if.paddr = '0; apb_if.pwdata = '0;
    test_reset();
    test_single_event();
    test_threshold();
    test_timeout();
    test_disabled_event();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
